// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter.
// The master drives the count controls and observes the count and flags;
// the slave side is the counter itself.
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);

  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             up_down;
  logic [WIDTH-1:0] modulo;
  logic             clear_flags;
  logic [WIDTH-1:0] count_out;
  logic             terminal;
  logic             overflow;
  logic             underflow;

  modport master (
    output enable,
    output load,
    output load_value,
    output up_down,
    output modulo,
    output clear_flags,
    input  count_out,
    input  terminal,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  enable,
    input  load,
    input  load_value,
    input  up_down,
    input  modulo,
    input  clear_flags,
    output count_out,
    output terminal,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/mod_updown_counter.sv
// Programmable up/down counter with runtime modulo limit, parallel load,
// enable prescaler, wrap or saturate at the limits, a one-cycle terminal
// pulse and sticky overflow/underflow flags. All outputs are registered.
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  mod_updown_counter_if.slave  bus
);

  // Prescale counter needs to hold 0..PRESCALE-1; keep at least one bit.
  localparam int PC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRESCALE - 1);
  localparam bit SAT_MODE = (SATURATE != 0);

  logic [WIDTH-1:0] count_r;
  logic [PC_W-1:0]  pc_r;
  logic             terminal_r;
  logic             overflow_r;
  logic             underflow_r;

  logic [WIDTH-1:0] count_nxt_s;
  logic [PC_W-1:0]  pc_nxt_s;
  logic             terminal_nxt_s;
  logic             overflow_nxt_s;
  logic             underflow_nxt_s;
  logic             step_s;
  logic             at_top_s;
  logic             at_bottom_s;
  logic             ovf_event_s;
  logic             udf_event_s;
  logic [WIDTH-1:0] load_clamped_s;

  // Step qualification and limit detection. A count above a lowered
  // modulo is treated as sitting at the top limit for up steps.
  always_comb begin
    step_s         = bus.enable && !bus.load && (pc_r == PC_LAST);
    at_top_s       = (count_r >= bus.modulo);
    at_bottom_s    = (count_r == {WIDTH{1'b0}});
    load_clamped_s = (bus.load_value > bus.modulo) ? bus.modulo : bus.load_value;
  end

  // Prescaler: load restarts it, enable advances it, otherwise it holds.
  always_comb begin
    pc_nxt_s = pc_r;
    if (bus.load) begin
      pc_nxt_s = {PC_W{1'b0}};
    end else if (bus.enable) begin
      if (pc_r == PC_LAST) begin
        pc_nxt_s = {PC_W{1'b0}};
      end else begin
        pc_nxt_s = pc_r + PC_W'(1);
      end
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // Count update: load has priority over a step; limit steps wrap or saturate.
  always_comb begin
    count_nxt_s    = count_r;
    terminal_nxt_s = 1'b0;
    ovf_event_s    = 1'b0;
    udf_event_s    = 1'b0;
    if (bus.load) begin
      count_nxt_s = load_clamped_s;
    end else if (step_s) begin
      if (bus.up_down) begin
        if (at_top_s) begin
          terminal_nxt_s = 1'b1;
          ovf_event_s    = 1'b1;
          count_nxt_s    = SAT_MODE ? bus.modulo : {WIDTH{1'b0}};
        end else begin
          count_nxt_s = count_r + WIDTH'(1);
        end
      end else begin
        if (at_bottom_s) begin
          terminal_nxt_s = 1'b1;
          udf_event_s    = 1'b1;
          count_nxt_s    = SAT_MODE ? {WIDTH{1'b0}} : bus.modulo;
        end else begin
          count_nxt_s = count_r - WIDTH'(1);
        end
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Sticky flags: a set event on the same edge overrides clear_flags.
  always_comb begin
    overflow_nxt_s  = ovf_event_s | (overflow_r  & ~bus.clear_flags);
    underflow_nxt_s = udf_event_s | (underflow_r & ~bus.clear_flags);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_r     <= {WIDTH{1'b0}};
      pc_r        <= {PC_W{1'b0}};
      terminal_r  <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      count_r     <= count_nxt_s;
      pc_r        <= pc_nxt_s;
      terminal_r  <= terminal_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  assign bus.count_out = count_r;
  assign bus.terminal  = terminal_r;
  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: three instances (wrap/P1,
// wrap/P3, saturate/P1), a vector table, hand-written corner sequences and
// a randomized run against a behavioural model.
module tb_mod_updown_counter;

  localparam int W = 4;

  logic clock = 1'b0;
  logic rst_a, rst_b, rst_c;

  int n_cmp = 0;
  int n_bad = 0;

  mod_updown_counter_if #(.WIDTH(W)) ia ();
  mod_updown_counter_if #(.WIDTH(W)) ib ();
  mod_updown_counter_if #(.WIDTH(W)) ic ();

  mod_updown_counter #(.WIDTH(W), .PRESCALE(1), .SATURATE(0)) dut_a (
    .clock(clock), .reset(rst_a), .bus(ia.slave));
  mod_updown_counter #(.WIDTH(W), .PRESCALE(3), .SATURATE(0)) dut_b (
    .clock(clock), .reset(rst_b), .bus(ib.slave));
  mod_updown_counter #(.WIDTH(W), .PRESCALE(1), .SATURATE(1)) dut_c (
    .clock(clock), .reset(rst_c), .bus(ic.slave));

  always #5 clock = ~clock;

  typedef struct {
    bit rst; bit en; bit ld; int lv; bit ud; int md; bit clr;
    int ec; bit et; bit eo; bit eu;
  } vec_t;

  typedef struct {
    int count; int enabled_edges; bit term; bit ovf; bit udf;
  } mstate_t;

  vec_t tbl[$];
  mstate_t ma, mb, mc;

  function automatic vec_t mk(bit rst, bit en, bit ld, int lv, bit ud, int md,
                              bit clr, int ec, bit et, bit eo, bit eu);
    vec_t v;
    v.rst = rst; v.en = en; v.ld = ld; v.lv = lv; v.ud = ud; v.md = md;
    v.clr = clr; v.ec = ec; v.et = et; v.eo = eo; v.eu = eu;
    return v;
  endfunction

  // Reference: the prescaler is a count of enabled edges since the last
  // load/reset; every P-th such edge is a step.
  function automatic mstate_t model(mstate_t s, int p, bit sat, bit rst, bit en,
                                    bit ld, int lv, bit ud, int md, bit clr);
    mstate_t n = s;
    n.term = 1'b0;
    if (rst) begin
      n.count = 0; n.enabled_edges = 0; n.ovf = 0; n.udf = 0;
      return n;
    end
    if (clr) begin n.ovf = 0; n.udf = 0; end
    if (ld) begin
      n.count = (lv < md) ? lv : md;
      n.enabled_edges = 0;
    end else if (en) begin
      n.enabled_edges = s.enabled_edges + 1;
      if (n.enabled_edges % p == 0) begin
        if (ud) begin
          if (s.count < md) n.count = s.count + 1;
          else begin n.term = 1; n.ovf = 1; n.count = sat ? md : 0; end
        end else begin
          if (s.count > 0) n.count = s.count - 1;
          else begin n.term = 1; n.udf = 1; n.count = sat ? 0 : md; end
        end
      end
    end
    return n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drv_b(bit rst, bit en, bit ld, int lv, bit ud, int md, bit clr);
    rst_b = rst; ib.enable = en; ib.load = ld; ib.load_value = W'(lv);
    ib.up_down = ud; ib.modulo = W'(md); ib.clear_flags = clr;
  endtask

  task automatic drv_c(bit rst, bit en, bit ld, int lv, bit ud, int md, bit clr);
    rst_c = rst; ic.enable = en; ic.load = ld; ic.load_value = W'(lv);
    ic.up_down = ud; ic.modulo = W'(md); ic.clear_flags = clr;
  endtask

  task automatic chk_b(string nm, int c, bit t, bit o, bit u);
    chk({nm, ".count"}, 32'(ib.count_out), 32'(c));
    chk({nm, ".term"},  32'(ib.terminal),  32'(t));
    chk({nm, ".ovf"},   32'(ib.overflow),  32'(o));
    chk({nm, ".udf"},   32'(ib.underflow), 32'(u));
  endtask

  task automatic chk_c(string nm, int c, bit t, bit o, bit u);
    chk({nm, ".count"}, 32'(ic.count_out), 32'(c));
    chk({nm, ".term"},  32'(ic.terminal),  32'(t));
    chk({nm, ".ovf"},   32'(ic.overflow),  32'(o));
    chk({nm, ".udf"},   32'(ic.underflow), 32'(u));
  endtask

  initial begin
    int pb_cnt[7];
    bit pb_en[7];

    // Vector table for the wrapping, unprescaled instance.
    tbl.push_back(mk(1,0,0,0,1,9,0, 0,0,0,0));
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0,1,0,0,1,9,0, i,0,0,0));
    tbl.push_back(mk(0,1,0,0,1,9,0, 0,1,1,0));   // 9 -> 0 wrap
    tbl.push_back(mk(0,1,0,0,1,9,0, 1,0,1,0));
    tbl.push_back(mk(0,1,1,3,0,9,0, 3,0,1,0));   // load with enable: no step
    tbl.push_back(mk(0,1,0,0,0,9,0, 2,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,9,0, 1,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,9,0, 0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0,9,0, 9,1,1,1));   // 0 -> 9 underflow
    tbl.push_back(mk(0,0,0,0,0,9,1, 9,0,0,0));   // clear alone
    tbl.push_back(mk(0,0,1,12,1,7,0, 7,0,0,0));  // load clamps to modulo
    tbl.push_back(mk(0,1,0,0,1,3,0, 0,1,1,0));   // modulo lowered below count
    tbl.push_back(mk(0,1,0,0,0,3,0, 3,1,1,1));   // down at 0 wraps to modulo
    tbl.push_back(mk(0,1,0,0,0,3,0, 2,0,1,1));   // down above lowered limit
    tbl.push_back(mk(0,1,0,0,1,0,0, 0,1,1,1));   // modulo 0, up
    tbl.push_back(mk(0,1,0,0,0,0,0, 0,1,1,1));   // modulo 0, down
    tbl.push_back(mk(1,1,1,5,1,9,0, 0,0,0,0));   // reset beats load

    rst_a = 1'b1; ia.enable = 0; ia.load = 0; ia.load_value = '0;
    ia.up_down = 1; ia.modulo = W'(9); ia.clear_flags = 0;
    drv_b(1,0,0,0,1,15,0);
    drv_c(1,0,0,0,1,5,0);

    foreach (tbl[k]) begin
      rst_a = tbl[k].rst; ia.enable = tbl[k].en; ia.load = tbl[k].ld;
      ia.load_value = W'(tbl[k].lv); ia.up_down = tbl[k].ud;
      ia.modulo = W'(tbl[k].md); ia.clear_flags = tbl[k].clr;
      tick();
      chk($sformatf("tbl%0d.count", k), 32'(ia.count_out), 32'(tbl[k].ec));
      chk($sformatf("tbl%0d.term", k),  32'(ia.terminal),  32'(tbl[k].et));
      chk($sformatf("tbl%0d.ovf", k),   32'(ia.overflow),  32'(tbl[k].eo));
      chk($sformatf("tbl%0d.udf", k),   32'(ia.underflow), 32'(tbl[k].eu));
    end

    // Prescale 3: six enabled edges with one gap give two steps.
    drv_b(1,0,0,0,1,15,0); tick(); chk_b("pre_rst", 0,0,0,0);
    pb_en  = '{1,1,0,1,1,1,1};
    pb_cnt = '{0,0,0,1,1,1,2};
    for (int i = 0; i < 7; i++) begin
      drv_b(0,pb_en[i],0,0,1,15,0); tick();
      chk($sformatf("pre%0d.count", i), 32'(ib.count_out), 32'(pb_cnt[i]));
    end
    // Reset mid-prescale with load asserted, then a full prescale period.
    drv_b(0,0,1,6,1,15,0); tick(); chk_b("pre_ld6", 6,0,0,0);
    drv_b(0,1,0,0,1,15,0); tick(); chk_b("pre_mid", 6,0,0,0);
    drv_b(1,1,1,9,1,15,0); tick(); chk_b("pre_rst2", 0,0,0,0);
    drv_b(0,1,0,0,1,15,0); tick(); chk_b("pre_e1", 0,0,0,0);
    tick(); chk_b("pre_e2", 0,0,0,0);
    tick(); chk_b("pre_e3", 1,0,0,0);

    // Saturating instance: hold at modulo, flag priority over clear.
    drv_c(1,0,0,0,1,5,0); tick(); chk_c("sat_rst", 0,0,0,0);
    drv_c(0,0,1,4,1,5,0); tick(); chk_c("sat_ld4", 4,0,0,0);
    drv_c(0,1,0,0,1,5,0); tick(); chk_c("sat_s1", 5,0,0,0);
    tick(); chk_c("sat_s2", 5,1,1,0);
    tick(); chk_c("sat_s3", 5,1,1,0);
    drv_c(0,1,0,0,1,5,1); tick(); chk_c("sat_clr_set", 5,1,1,0);
    drv_c(0,0,0,0,1,5,1); tick(); chk_c("sat_clr", 5,0,0,0);
    drv_c(0,0,1,0,0,5,0); tick(); chk_c("sat_ld0", 0,0,0,0);
    drv_c(0,1,0,0,0,5,0); tick(); chk_c("sat_dn0", 0,1,0,1);

    // Randomized run on all three instances against the model.
    drv_b(1,0,0,0,1,15,0); drv_c(1,0,0,0,1,5,0); rst_a = 1'b1;
    tick();
    ma = '{0,0,0,0,0}; mb = ma; mc = ma;
    for (int i = 0; i < 400; i++) begin
      bit r, e, l, u, c; int lv, md;
      r  = ($urandom_range(99) < 2);
      e  = ($urandom_range(99) < 75);
      l  = ($urandom_range(99) < 8);
      u  = ($urandom_range(99) < 60);
      c  = ($urandom_range(99) < 6);
      lv = $urandom_range(15);
      md = ($urandom_range(9) == 0) ? $urandom_range(15) : 9 + $urandom_range(3);
      rst_a = r; ia.enable = e; ia.load = l; ia.load_value = W'(lv);
      ia.up_down = u; ia.modulo = W'(md); ia.clear_flags = c;
      drv_b(r,e,l,lv,u,md,c);
      drv_c(r,e,l,lv,u,md,c);
      ma = model(ma, 1, 0, r, e, l, lv, u, md, c);
      mb = model(mb, 3, 0, r, e, l, lv, u, md, c);
      mc = model(mc, 1, 1, r, e, l, lv, u, md, c);
      tick();
      chk("rnd_a.count", 32'(ia.count_out), 32'(ma.count));
      chk("rnd_a.term",  32'(ia.terminal),  32'(ma.term));
      chk("rnd_a.ovf",   32'(ia.overflow),  32'(ma.ovf));
      chk("rnd_a.udf",   32'(ia.underflow), 32'(ma.udf));
      chk_b("rnd_b", mb.count, mb.term, mb.ovf, mb.udf);
      chk_c("rnd_c", mc.count, mc.term, mc.ovf, mc.udf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
